// File: rtl/rng_pkg.sv
// +----------------------------------------------------------------------+
// | rng_pkg: shared state encoding and Galois LFSR helpers for roulette  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rng_pkg;

  localparam int IV_W = 32;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      8:       tap_mask = 32'h0000_00B8;
      16:      tap_mask = 32'h0000_B400;
      24:      tap_mask = 32'h00E1_0000;
      default: tap_mask = 32'hA300_0000;
    endcase
  endfunction

  // Right-shifting Galois step; inputs narrower than 32 bits are zero-extended.
  function automatic logic [31:0] galois_next(input logic [31:0] v, input int width);
    galois_next = (v >> 1) ^ (v[0] ? tap_mask(width) : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_galois.sv
// +----------------------------------------------------------------------+
// | lfsr_galois: W-bit Galois LFSR with seed load and enable-step        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lfsr_galois
  import rng_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_seed,
  input  logic         i_step,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= W'(1);
    end else if (i_load) begin
      r_q <= i_seed;
    end else if (i_step) begin
      r_q <= W'(galois_next(32'(r_q), W));
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/lfsr_roulette.sv
// +----------------------------------------------------------------------+
// | lfsr_roulette: seeded LFSR that spins for NUM_STEPS updates, then    |
// | settles. Define RNG_DECEL_EN for a growing update interval.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lfsr_roulette
  import rng_pkg::*;
#(
  parameter int          OUT_W         = 4,
  parameter int          LFSR_W        = 16,
  parameter int unsigned INIT_INTERVAL = 500000,
  parameter int          NUM_STEPS     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [OUT_W-1:0] o_random_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam int                  c_step_w    = $clog2(NUM_STEPS + 1);
  localparam logic [c_step_w-1:0] c_last_step = c_step_w'(NUM_STEPS - 1);
  localparam logic [c_step_w-1:0] c_step_one  = c_step_w'(1);
  localparam logic [IV_W-1:0]     c_init_iv   = IV_W'(INIT_INTERVAL);
  localparam logic [IV_W-1:0]     c_iv_one    = IV_W'(1);

  state_t              r_state;
  logic [LFSR_W-1:0]   r_seed_cnt;
  logic [IV_W-1:0]     r_ic;
  logic [IV_W-1:0]     r_interval;
  logic [c_step_w-1:0] r_step;
  logic                r_stop_req;
  logic [OUT_W-1:0]    r_random;
  logic                r_busy;
  logic                r_done;

  logic                w_start;
  logic                w_update;
  logic                w_final;
  logic [LFSR_W-1:0]   w_lfsr_q;
  logic [OUT_W-1:0]    w_next_out;

  assign w_start    = (r_state == S_IDLE) && i_start;
  assign w_update   = (r_state == S_RUN) && (r_ic == (r_interval - c_iv_one));
  assign w_final    = w_update && ((r_step == c_last_step) || r_stop_req);
  assign w_next_out = OUT_W'(galois_next(32'(w_lfsr_q), LFSR_W));

`ifdef RNG_DECEL_EN
  logic [IV_W:0]   w_iv_sum;
  logic [IV_W-1:0] w_iv_grown;

  // Grow by a quarter each step, clamping at the 32-bit ceiling.
  assign w_iv_sum   = {1'b0, r_interval} + {1'b0, (r_interval >> 2)};
  assign w_iv_grown = w_iv_sum[IV_W] ? '1 : w_iv_sum[IV_W-1:0];
`endif

  lfsr_galois #(
    .W (LFSR_W)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_start),
    .i_seed  (r_seed_cnt | LFSR_W'(1)),
    .i_step  (w_update),
    .o_q     (w_lfsr_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_seed_cnt <= '0;
      r_ic       <= '0;
      r_interval <= c_init_iv;
      r_step     <= '0;
      r_stop_req <= 1'b0;
      r_random   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_seed_cnt <= r_seed_cnt + LFSR_W'(1);
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_random   <= '0;
            r_step     <= '0;
            r_ic       <= '0;
            r_interval <= c_init_iv;
            r_stop_req <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_stop_req <= 1'b1;
          end
          if (w_update) begin
            r_random <= w_next_out;
            r_ic     <= '0;
            r_step   <= r_step + c_step_one;
            if (w_final) begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_stop_req <= 1'b0;
            end else begin
`ifdef RNG_DECEL_EN
              r_interval <= w_iv_grown;
`endif
            end
          end else begin
            r_ic <= r_ic + c_iv_one;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_random_out = r_random;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_roulette.sv
// +----------------------------------------------------------------------+
// | tb_lfsr_roulette: directed self-checking bench for lfsr_roulette     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lfsr_roulette;

  localparam int U1 = 4;
`ifdef RNG_DECEL_EN
  localparam int U2 = 9;
  localparam int U3 = 15;
`else
  localparam int U2 = 8;
  localparam int U3 = 12;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       start1;
  logic [3:0] out;
  logic [3:0] out1;
  logic       busy;
  logic       done;
  logic       busy1;
  logic       done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_roulette #(
    .OUT_W         (4),
    .LFSR_W        (8),
    .INIT_INTERVAL (4),
    .NUM_STEPS     (3)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .o_random_out (out),
    .o_busy       (busy),
    .o_done       (done)
  );

  lfsr_roulette #(
    .OUT_W         (4),
    .LFSR_W        (8),
    .INIT_INTERVAL (2),
    .NUM_STEPS     (1)
  ) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start1),
    .i_stop       (1'b0),
    .o_random_out (out1),
    .o_busy       (busy1),
    .o_done       (done1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release reset and start on the very next edge, so the seed is 0x01.
  task automatic reset_start(input bit use1);
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if (use1) start1 = 1'b1;
    else      start  = 1'b1;
    cyc();
    if (use1) begin
      chk("busy1_T", {7'd0, busy1}, 8'd1);
      chk("out1_T", {4'd0, out1}, 8'h0);
    end else begin
      chk("busy_T", {7'd0, busy}, 8'd1);
      chk("out_T", {4'd0, out}, 8'h0);
    end
  endtask

  task automatic run_roll(input bit pulses);
    logic [3:0] exp_out;
    for (int k = 1; k <= U3 + 1; k++) begin
      start = pulses && (k == 3 || k == 7 || k == U3);
      cyc();
      exp_out = (k < U1) ? 4'h0 : (k < U2) ? 4'h8 : (k < U3) ? 4'hC : 4'hE;
      chk($sformatf("out@T+%0d", k), {4'd0, out}, {4'd0, exp_out});
      chk($sformatf("done@T+%0d", k), {7'd0, done}, {7'd0, (k == U3)});
      chk($sformatf("busy@T+%0d", k), {7'd0, busy}, {7'd0, (k < U3)});
    end
    start = 1'b0;
    repeat (3) cyc();
    chk("out_hold", {4'd0, out}, 8'hE);
    chk("busy_idle", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", {4'd0, out}, 8'h0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_out1", {4'd0, out1}, 8'h0);

    // Basic roll from seed 0x01
    reset_start(1'b0);
    run_roll(1'b0);

    // Stop one cycle after start: single update at T+4
    reset_start(1'b0);
    start = 1'b0;
    stop  = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_busy@T+1", {7'd0, busy}, 8'd1);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk($sformatf("stop_out@T+%0d", k), {4'd0, out}, (k == 4) ? 8'h8 : 8'h0);
      chk($sformatf("stop_done@T+%0d", k), {7'd0, done}, {7'd0, (k == 4)});
      chk($sformatf("stop_busy@T+%0d", k), {7'd0, busy}, {7'd0, (k < 4)});
    end
    cyc();
    chk("stop_done_fall", {7'd0, done}, 8'd0);
    chk("stop_out_hold", {4'd0, out}, 8'h8);

    // Start pulses while running, including on the final edge, are ignored
    reset_start(1'b0);
    run_roll(1'b1);

    // Asynchronous reset mid-roll
    reset_start(1'b0);
    start = 1'b0;
    repeat (5) cyc();
    chk("pre_rst_out", {4'd0, out}, 8'h8);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {4'd0, out}, 8'h0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("midrst_done", {7'd0, done}, 8'd0);
    end
    reset_start(1'b0);
    run_roll(1'b0);

    // NUM_STEPS=1, INIT_INTERVAL=2
    reset_start(1'b1);
    start1 = 1'b0;
    cyc();
    chk("n1_out@T+1", {4'd0, out1}, 8'h0);
    chk("n1_done@T+1", {7'd0, done1}, 8'd0);
    chk("n1_busy@T+1", {7'd0, busy1}, 8'd1);
    cyc();
    chk("n1_out@T+2", {4'd0, out1}, 8'h8);
    chk("n1_done@T+2", {7'd0, done1}, 8'd1);
    chk("n1_busy@T+2", {7'd0, busy1}, 8'd0);
    cyc();
    chk("n1_done@T+3", {7'd0, done1}, 8'd0);
    chk("n1_out@T+3", {4'd0, out1}, 8'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
